// File: rtl/reg_read_stage.sv
// Register-read stage: reads source operands from the PRF (with writeback bypass)
// and hands micro-ops to execute through a registered output plus a one-entry skid.
module reg_read_stage #(
  parameter  int NUM_PREGS = 64,
  parameter  int XLEN      = 32,
  parameter  int NUM_WB    = 2,
  parameter  int UOP_W     = 16,
  parameter  int ROB_W     = 5,
  localparam int PW        = $clog2(NUM_PREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic [PW-1:0]          iss_src1_reg,
  input  logic [PW-1:0]          iss_src2_reg,
  input  logic [PW-1:0]          iss_dst_reg,
  input  logic [UOP_W-1:0]       iss_uop,
  input  logic [ROB_W-1:0]       iss_rob_idx,
  output logic [PW-1:0]          prf_src1_reg,
  output logic [PW-1:0]          prf_src2_reg,
  input  logic [XLEN-1:0]        prf_src1_val,
  input  logic [XLEN-1:0]        prf_src2_val,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*PW-1:0]   wb_dst_reg,
  input  logic [NUM_WB*XLEN-1:0] wb_val,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [XLEN-1:0]        ex_src1_val,
  output logic [XLEN-1:0]        ex_src2_val,
  output logic [PW-1:0]          ex_dst_reg,
  output logic [UOP_W-1:0]       ex_uop,
  output logic [ROB_W-1:0]       ex_rob_idx
);

  typedef struct packed {
    logic [XLEN-1:0]  s1;
    logic [XLEN-1:0]  s2;
    logic [PW-1:0]    dst;
    logic [UOP_W-1:0] uop;
    logic [ROB_W-1:0] rob;
  } ent_t;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  state_t r_state;
  ent_t   r_out, r_skid;
  logic   r_iss_ready;

  state_t w_nxt;
  ent_t   w_new;
  logic   w_accept, w_xfer, w_hit1, w_hit2;

  assign prf_src1_reg = iss_src1_reg;
  assign prf_src2_reg = iss_src2_reg;
  assign iss_ready    = r_iss_ready;
  assign ex_valid     = (r_state != S_EMPTY);
  assign w_accept     = iss_valid && r_iss_ready && !flush;
  assign w_xfer       = ex_valid && ex_ready;

  assign ex_src1_val = r_out.s1;
  assign ex_src2_val = r_out.s2;
  assign ex_dst_reg  = r_out.dst;
  assign ex_uop      = r_out.uop;
  assign ex_rob_idx  = r_out.rob;

  // Lowest-index writeback port wins; preg 0 always reads zero.
  always_comb begin
    w_new.s1  = prf_src1_val;
    w_new.s2  = prf_src2_val;
    w_new.dst = iss_dst_reg;
    w_new.uop = iss_uop;
    w_new.rob = iss_rob_idx;
    w_hit1    = 1'b0;
    w_hit2    = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (!w_hit1 && wb_valid[p] && wb_dst_reg[p*PW +: PW] == iss_src1_reg) begin
        w_new.s1 = wb_val[p*XLEN +: XLEN];
        w_hit1   = 1'b1;
      end
      if (!w_hit2 && wb_valid[p] && wb_dst_reg[p*PW +: PW] == iss_src2_reg) begin
        w_new.s2 = wb_val[p*XLEN +: XLEN];
        w_hit2   = 1'b1;
      end
    end
    if (iss_src1_reg == '0) w_new.s1 = '0;
    if (iss_src2_reg == '0) w_new.s2 = '0;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_nxt = S_FULL;
      S_FULL: begin
        if (w_accept && !w_xfer)      w_nxt = S_SKID;
        else if (!w_accept && w_xfer) w_nxt = S_EMPTY;
      end
      S_SKID:  if (w_xfer) w_nxt = S_FULL;
      default: w_nxt = S_EMPTY;
    endcase
    if (flush) w_nxt = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_iss_ready <= 1'b0;
      r_out       <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_nxt;
      r_iss_ready <= (w_nxt != S_SKID);
      if (!flush) begin
        case (r_state)
          S_EMPTY: if (w_accept) r_out <= w_new;
          S_FULL: begin
            if (w_accept && w_xfer) r_out  <= w_new;
            else if (w_accept)      r_skid <= w_new;
          end
          S_SKID:  if (w_xfer) r_out <= r_skid;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage with a scoreboard of expected micro-ops.
module tb_reg_read_stage;
  localparam int PW = 6, XLEN = 32, NUM_WB = 2, UOP_W = 16, ROB_W = 5;

  typedef struct {
    logic [XLEN-1:0]  s1, s2;
    logic [PW-1:0]    dst;
    logic [UOP_W-1:0] uop;
    logic [ROB_W-1:0] rob;
  } exp_t;

  logic clk = 0, rst = 1, flush = 0, iss_valid = 0, iss_ready, ex_valid, ex_ready = 0;
  logic [PW-1:0] iss_src1_reg = 0, iss_src2_reg = 0, iss_dst_reg = 0, prf_src1_reg, prf_src2_reg, ex_dst_reg;
  logic [UOP_W-1:0] iss_uop = 0, ex_uop;
  logic [ROB_W-1:0] iss_rob_idx = 0, ex_rob_idx;
  logic [XLEN-1:0] prf_src1_val, prf_src2_val, ex_src1_val, ex_src2_val;
  logic [NUM_WB-1:0] wb_valid = 0;
  logic [NUM_WB*PW-1:0] wb_dst_reg = 0;
  logic [NUM_WB*XLEN-1:0] wb_val = 0;

  logic [XLEN-1:0] prf [64];
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  assign prf_src1_val = prf[prf_src1_reg];
  assign prf_src2_val = prf[prf_src2_reg];

  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1_reg(iss_src1_reg), .iss_src2_reg(iss_src2_reg), .iss_dst_reg(iss_dst_reg),
    .iss_uop(iss_uop), .iss_rob_idx(iss_rob_idx),
    .prf_src1_reg(prf_src1_reg), .prf_src2_reg(prf_src2_reg),
    .prf_src1_val(prf_src1_val), .prf_src2_val(prf_src2_val),
    .wb_valid(wb_valid), .wb_dst_reg(wb_dst_reg), .wb_val(wb_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_src1_val(ex_src1_val), .ex_src2_val(ex_src2_val),
    .ex_dst_reg(ex_dst_reg), .ex_uop(ex_uop), .ex_rob_idx(ex_rob_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] opnd(input logic [PW-1:0] tag);
    if (tag == 0) return 0;
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid[p] && wb_dst_reg[p*PW +: PW] == tag) return wb_val[p*XLEN +: XLEN];
    return prf[tag];
  endfunction

  // One clock: score the transfer / accept seen mid-cycle, then advance past the edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (ex_valid && ex_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("ex_src1_val", ex_src1_val, e.s1);
        chk("ex_src2_val", ex_src2_val, e.s2);
        chk("ex_dst_reg",  ex_dst_reg,  e.dst);
        chk("ex_uop",      ex_uop,      e.uop);
        chk("ex_rob_idx",  ex_rob_idx,  e.rob);
      end
    end
    if (iss_valid && iss_ready && !flush && !rst) begin
      e.s1 = opnd(iss_src1_reg); e.s2 = opnd(iss_src2_reg);
      e.dst = iss_dst_reg; e.uop = iss_uop; e.rob = iss_rob_idx;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (flush || rst) sb.delete();
  endtask

  task automatic iss(input logic v, input logic [PW-1:0] s1, input logic [PW-1:0] s2,
                     input logic [PW-1:0] d, input logic [UOP_W-1:0] u, input logic [ROB_W-1:0] r);
    iss_valid = v; iss_src1_reg = s1; iss_src2_reg = s2; iss_dst_reg = d; iss_uop = u; iss_rob_idx = r;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prf[i] = 32'h1000 + i;
    prf[7] = 12; prf[8] = 13; prf[5] = 55;

    // reset
    step(); chk("rst_iss_ready", iss_ready, 0); chk("rst_ex_valid", ex_valid, 0);
    step(); chk("rst_ex_src1", ex_src1_val, 0);
    rst = 0;
    step(); chk("post_rst_iss_ready", iss_ready, 1); chk("post_rst_ex_valid", ex_valid, 0);

    // basic read
    ex_ready = 1;
    iss(1, 7, 8, 9, 16'hA001, 1); step();
    iss(0, 0, 0, 0, 0, 0);
    chk("basic_ex_valid", ex_valid, 1);
    step(); chk("basic_drained", ex_valid, 0);

    // bypass: port 0 hit, zero tag, both sources from one port, port priority
    iss(1, 7, 5, 10, 16'hB001, 2);
    wb_valid = 2'b01; wb_dst_reg = {6'd0, 6'd7}; wb_val = {32'd0, 32'd99}; step();
    iss(1, 0, 0, 11, 16'hB002, 3);
    wb_valid = 2'b11; wb_dst_reg = {6'd0, 6'd0}; wb_val = {32'd77, 32'd66}; step();
    iss(1, 3, 3, 12, 16'hB003, 4);
    wb_valid = 2'b10; wb_dst_reg = {6'd3, 6'd9}; wb_val = {32'h1234, 32'h5}; step();
    iss(1, 4, 6, 13, 16'hB004, 5);
    wb_valid = 2'b11; wb_dst_reg = {6'd4, 6'd4}; wb_val = {32'hBBBB, 32'hAAAA}; step();
    iss(0, 0, 0, 0, 0, 0); wb_valid = 0;
    step(); step();

    // backpressure
    ex_ready = 0;
    iss(1, 20, 21, 22, 16'hC001, 6); step();
    chk("bp_ready_after_A", iss_ready, 1);
    iss(1, 23, 24, 25, 16'hC002, 7); step();
    iss(0, 0, 0, 0, 0, 0);
    chk("bp_ready_low", iss_ready, 0); chk("bp_ex_valid", ex_valid, 1);
    chk("bp_hold_A_src1", ex_src1_val, prf[20]); chk("bp_hold_A_dst", ex_dst_reg, 22);
    step();
    chk("bp_stable_src2", ex_src2_val, prf[21]); chk("bp_stable_ready", iss_ready, 0);
    ex_ready = 1; step();
    chk("bp_ready_back", iss_ready, 1); chk("bp_B_out", ex_dst_reg, 25);
    step(); chk("bp_drained", ex_valid, 0);

    // streaming
    for (int i = 0; i < 4; i++) begin
      iss(1, PW'(30 + i), PW'(40 + i), PW'(50 + i), UOP_W'(16'hD000 + i), ROB_W'(8 + i)); step();
      chk("stream_ready", iss_ready, 1); chk("stream_valid", ex_valid, 1);
    end
    iss(0, 0, 0, 0, 0, 0); step();
    chk("stream_drained", ex_valid, 0);

    // flush from SKID_FULL with issue offered
    ex_ready = 0;
    iss(1, 1, 2, 3, 16'hE001, 12); step();
    iss(1, 4, 5, 6, 16'hE002, 13); step();
    chk("fl_skid_ready", iss_ready, 0);
    iss(1, 7, 8, 9, 16'hE003, 14); flush = 1; step();
    flush = 0; iss(0, 0, 0, 0, 0, 0);
    chk("fl_ex_valid", ex_valid, 0); chk("fl_iss_ready", iss_ready, 1);
    step(); chk("fl_not_captured", ex_valid, 0);
    // flush from FULL while iss_ready high: offered uop must be dropped
    iss(1, 10, 11, 12, 16'hE004, 15); step();
    iss(1, 13, 14, 15, 16'hE005, 16); flush = 1; step();
    flush = 0; iss(0, 0, 0, 0, 0, 0);
    step(); chk("fl_full_ex_valid", ex_valid, 0);

    // reset mid-operation
    iss(1, 17, 18, 19, 16'hF001, 17); step();
    iss(0, 0, 0, 0, 0, 0);
    chk("rm_full", ex_valid, 1);
    rst = 1; step();
    chk("rm_ex_valid", ex_valid, 0); chk("rm_ready", iss_ready, 0);
    chk("rm_src1", ex_src1_val, 0); chk("rm_dst", ex_dst_reg, 0);
    step(); chk("rm_ready2", iss_ready, 0);
    rst = 0; step();
    chk("rm_ready_after", iss_ready, 1); chk("rm_valid_after", ex_valid, 0);

    // final drain check, bounded
    ex_ready = 1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Register-read pipeline stage between the issue queue and the functional units. It accepts issued micro-ops over a valid/ready handshake and drives their source tags onto the physical register file read port. It captures the operand values, forwarding same-cycle writebacks from the execute write ports, and presents fully-read micro-ops to execute through a registered output with a one-entry skid buffer.

## Interface
- NUM_PREGS, 64, physical registers; tag width PW = $clog2(NUM_PREGS)
- XLEN, 32, operand width
- NUM_WB, 2, execute writeback ports snooped for bypass
- UOP_W, 16, opaque micro-op payload width
- ROB_W, 5, ROB index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kills all held micro-ops this cycle
- iss_valid  in  1  issue offers a micro-op
- iss_ready  out  1  stage can accept
- iss_src1_reg, iss_src2_reg  in  PW  source physical tags
- iss_dst_reg  in  PW  destination tag, passed through
- iss_uop  in  UOP_W  payload, passed through
- iss_rob_idx  in  ROB_W  passed through
- prf_src1_reg, prf_src2_reg  out  PW  register file read addresses (combinational from iss_src*_reg)
- prf_src1_val, prf_src2_val  in  XLEN  register file read data, same-cycle combinational
- wb_valid  in  NUM_WB  execute writeback valid per port
- wb_dst_reg  in  NUM_WB*PW  writeback tags
- wb_val  in  NUM_WB*XLEN  writeback data
- ex_valid  out  1  output micro-op valid
- ex_ready  in  1  execute accepts
- ex_src1_val, ex_src2_val  out  XLEN  operands
- ex_dst_reg  out  PW; ex_uop  out  UOP_W; ex_rob_idx  out  ROB_W

## Operation
- Accept = iss_valid && iss_ready && !flush. Handshake on ex side: transfer = ex_valid && ex_ready.
- Operand select per source, in priority order: tag 0 -> 0 (preg 0 hardwired zero); lowest-index wb port with wb_valid && wb_dst_reg == tag -> wb_val; otherwise prf_srcN_val. Bypass covers the register file's write-at-edge latency.
- Two storage entries: OUT (drives ex_*) and SKID. State machine over {EMPTY, FULL, SKID_FULL}:
  - EMPTY: accept -> FULL (captured into OUT).
  - FULL: accept && transfer -> FULL (OUT replaced). Accept && !transfer -> SKID_FULL (captured into SKID). !accept && transfer -> EMPTY.
  - SKID_FULL: transfer -> FULL (SKID moves to OUT). Accept cannot occur.
- iss_ready = registered, 1 iff next state != SKID_FULL; 0 while rst high.
- ex_valid = state != EMPTY.
- Captured values are final. Entries never re-snoop wb; issue guarantees sources are produced no later than the accept cycle.
- flush: next state EMPTY and both entries invalidated, overriding accept and transfer. A transfer coinciding with flush still counts at execute; execute discards it on flush itself.
- Payload fields (dst, uop, rob_idx) travel unchanged with their operands.

## Timing
- Latency: accepted at edge N -> ex_valid with captured operands visible after edge N; earliest transfer at edge N+1.
- Throughput: 1 micro-op/cycle with ex_ready held high.
- Backpressure: first stalled accept fills SKID; iss_ready low starting the cycle after. iss_ready returns high the cycle after SKID drains into OUT.
- Reset values: ex_valid 0, iss_ready 0 during reset and 1 from the first cycle after. ex_* data 0, state EMPTY. Reset mid-operation discards both entries with no transfer.
- ex_* data are stable while ex_valid && !ex_ready (no change until transfer or flush).
- Simultaneous bypass hits on both sources from the same wb port: both sources get wb_val.

## Test plan
- Basic read: PRF[7]=12, PRF[8]=13; issue src1=7, src2=8, dst=9 -> next cycle ex_valid=1, ex_src1_val=12, ex_src2_val=13, ex_dst_reg=9.
- Bypass: PRF[7]=12; same cycle as the issue of src1=7, drive wb_valid[0]=1, wb_dst_reg=7, wb_val=99 -> ex_src1_val=99. With src=0 and a wb to tag 0 -> operand 0.
- Backpressure: ex_ready=0, issue A then B -> A held on ex_*, iss_ready low the following cycle. Raise ex_ready -> A then B on consecutive cycles, iss_ready high again, no loss or reorder.
- Streaming: ex_ready=1, 4 back-to-back issues -> 4 consecutive ex_valid cycles in order, iss_ready constantly 1.
- Flush: SKID_FULL state, assert flush with iss_valid=1 -> next cycle ex_valid=0, iss_ready=1, flushed issue not captured.
- Reset mid-operation: FULL with ex_ready=0, assert rst 2 cycles -> ex_valid=0, ex data 0, iss_ready=0 during reset and 1 the cycle after.
